// File: rtl/game_pkg.sv
// Shared geometry, rival FSM state type and lane-to-x mapping for the racing game.
package game_pkg;

  localparam int SCREEN_H    = 480;
  localparam int ROAD_X_MIN  = 192;
  localparam int LANE_W      = 64;
  localparam int LANE_OFFSET = 16;

  typedef enum logic {ACTIVE, WAIT} rival_state_t;

  function automatic logic [9:0] lane_to_x(input logic [1:0] lane);
    return 10'(ROAD_X_MIN + int'(lane) * LANE_W + LANE_OFFSET);
  endfunction

endpackage

// File: rtl/rival_lane_sel.sv
// Picks the respawn lane from rnd; with RIVAL_LANE_AVOID_EN it never repeats prev_lane.
module rival_lane_sel
  import game_pkg::*;
(
  input  logic [7:0] rnd,
  input  logic [1:0] prev_lane,
  output logic [1:0] lane,
  output logic [9:0] x
);

`ifdef RIVAL_LANE_AVOID_EN
  assign lane = (rnd[1:0] == prev_lane) ? rnd[1:0] + 2'd1 : rnd[1:0];
  logic unused_bits;
  assign unused_bits = &{1'b0, rnd[7:2]};
`else
  assign lane = rnd[1:0];
  logic unused_bits;
  assign unused_bits = &{1'b0, rnd[7:2], prev_lane};
`endif

  assign x = lane_to_x(lane);

endmodule

// File: rtl/rival_car_core.sv
// One rival car: falls once per frame, hides on exit/collision, respawns after a hold-off.
// Optional macro RIVAL_LANE_AVOID_EN keeps consecutive spawns out of the same lane.
module rival_car_core
  import game_pkg::*;
#(
  parameter int BASE_SPEED     = 2,
  parameter int SPEED_W        = 4,
  parameter int RESPAWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_end,
  input  logic [7:0]         rnd,
  input  logic               collide_with_rival,
  input  logic [SPEED_W-1:0] SCROLL_SPEED_Y,
  output logic [9:0]         rival_x,
  output logic [9:0]         rival_y
);

  localparam int CW = $clog2(RESPAWN_FRAMES + 1);

  rival_state_t  state_reg, state_next;
  logic [9:0]    x_reg, x_next;
  logic [9:0]    y_reg, y_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    prev_lane;
  logic [1:0]    new_lane;
  logic [9:0]    new_x;
  logic [10:0]   y_sum;
  logic          hit_bottom;
  logic          respawn;

`ifdef RIVAL_LANE_AVOID_EN
  logic [1:0] lane_reg;
  always_ff @(posedge clk) begin
    if (reset)
      lane_reg <= 2'd0;
    else if (respawn)
      lane_reg <= new_lane;
  end
  assign prev_lane = lane_reg;
`else
  assign prev_lane = 2'd0;
  logic unused_lane;
  assign unused_lane = &{1'b0, new_lane};
`endif

  rival_lane_sel u_lane_sel (
    .rnd       (rnd),
    .prev_lane (prev_lane),
    .lane      (new_lane),
    .x         (new_x)
  );

  // 11-bit sum so a fast scroll near the bottom cannot wrap past 1023.
  assign y_sum      = {1'b0, y_reg} + 11'(BASE_SPEED) + 11'(SCROLL_SPEED_Y);
  assign hit_bottom = (y_sum >= 11'(SCREEN_H));
  assign respawn    = (state_reg == WAIT) && frame_end &&
                      (cnt_reg == CW'(RESPAWN_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ACTIVE;
      x_reg     <= lane_to_x(2'd0);
      y_reg     <= 10'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACTIVE: if (collide_with_rival || (frame_end && hit_bottom)) state_next = WAIT;
      WAIT:   if (respawn) state_next = ACTIVE;
      default: state_next = ACTIVE;
    endcase
  end

  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    cnt_next = cnt_reg;
    case (state_reg)
      ACTIVE: begin
        if (collide_with_rival || (frame_end && hit_bottom)) begin
          y_next   = 10'(SCREEN_H);
          cnt_next = '0;
        end else if (frame_end) begin
          y_next = y_sum[9:0];
        end
      end
      WAIT: begin
        if (respawn) begin
          y_next   = 10'd0;
          x_next   = new_x;
          cnt_next = '0;
        end else if (frame_end) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign rival_x = x_reg;
  assign rival_y = y_reg;

endmodule

// File: tb/tb_rival_car_core.sv
// Directed self-checking bench for rival_car_core (default build, lane = rnd[1:0]).
module tb_rival_car_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_end = 1'b0;
  logic [7:0] rnd = 8'h00;
  logic       collide_with_rival = 1'b0;
  logic [3:0] SCROLL_SPEED_Y = 4'd0;
  logic [9:0] rival_x;
  logic [9:0] rival_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rival_car_core dut (
    .clk                (clk),
    .reset              (reset),
    .frame_end          (frame_end),
    .rnd                (rnd),
    .collide_with_rival (collide_with_rival),
    .SCROLL_SPEED_Y     (SCROLL_SPEED_Y),
    .rival_x            (rival_x),
    .rival_y            (rival_y)
  );

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_end = 1'b1;
      @(negedge clk); frame_end = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    checks++; if (rival_x !== 10'd208) begin errors++; $display("FAIL reset_x got=%0d exp=208", rival_x); end
    checks++; if (rival_y !== 10'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", rival_y); end
    @(negedge clk);
    checks++; if (rival_y !== 10'd0) begin errors++; $display("FAIL idle_hold got=%0d exp=0", rival_y); end
    $display("test_reset x=%0d y=%0d", rival_x, rival_y);
  endtask

  task automatic test_descent;
    SCROLL_SPEED_Y = 4'd1;
    frames(125);
    checks++; if (rival_y !== 10'd375) begin errors++; $display("FAIL descent_125 got=%0d exp=375", rival_y); end
    frames(34);
    checks++; if (rival_y !== 10'd477) begin errors++; $display("FAIL descent_159 got=%0d exp=477", rival_y); end
    frames(1);
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL descent_exact_480 got=%0d exp=480", rival_y); end
    checks++; if (rival_x !== 10'd208) begin errors++; $display("FAIL descent_x_held got=%0d exp=208", rival_x); end
    $display("test_descent y=%0d", rival_y);
  endtask

  task automatic test_respawn;
    logic [7:0] rnd_tab [3] = '{8'h02, 8'hFF, 8'h01};
    logic [9:0] x_tab   [3] = '{10'd336, 10'd400, 10'd272};
    rnd = 8'h02;
    frames(7);
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL wait_7 got=%0d exp=480", rival_y); end
    frames(1);
    checks++; if (rival_y !== 10'd0) begin errors++; $display("FAIL respawn_y got=%0d exp=0", rival_y); end
    checks++; if (rival_x !== 10'd336) begin errors++; $display("FAIL respawn_x got=%0d exp=336", rival_x); end
    for (int p = 0; p < 3; p++) begin
      rnd = 8'h00;
      frames(125);
      checks++; if (rival_y !== 10'd375) begin errors++; $display("FAIL pass%0d_375 got=%0d exp=375", p, rival_y); end
      frames(35);
      checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL pass%0d_hidden got=%0d exp=480", p, rival_y); end
      rnd = rnd_tab[p];
      frames(8);
      checks++; if (rival_y !== 10'd0) begin errors++; $display("FAIL pass%0d_respawn_y got=%0d exp=0", p, rival_y); end
      checks++; if (rival_x !== x_tab[p]) begin errors++; $display("FAIL pass%0d_respawn_x got=%0d exp=%0d", p, rival_x, x_tab[p]); end
      $display("test_respawn pass=%0d rnd=%02h x=%0d", p, rnd, rival_x);
    end
  endtask

  task automatic test_collision;
    SCROLL_SPEED_Y = 4'd1;
    rnd = 8'h00;
    frames(30);
    checks++; if (rival_y !== 10'd90) begin errors++; $display("FAIL coll_pre got=%0d exp=90", rival_y); end
    @(negedge clk); frame_end = 1'b1; collide_with_rival = 1'b1;
    @(negedge clk); frame_end = 1'b0; collide_with_rival = 1'b0;
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL coll_priority got=%0d exp=480", rival_y); end
    collide_with_rival = 1'b1;
    frames(3);
    @(negedge clk);
    collide_with_rival = 1'b0;
    frames(4);
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL coll_wait_7 got=%0d exp=480", rival_y); end
    frames(1);
    checks++; if (rival_y !== 10'd0) begin errors++; $display("FAIL coll_wait_ignored got=%0d exp=0", rival_y); end
    checks++; if (rival_x !== 10'd208) begin errors++; $display("FAIL coll_respawn_x got=%0d exp=208", rival_x); end
    frames(2);
    @(negedge clk); collide_with_rival = 1'b1;
    @(negedge clk); collide_with_rival = 1'b0;
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL coll_no_frame got=%0d exp=480", rival_y); end
    rnd = 8'h03;
    frames(8);
    checks++; if (rival_x !== 10'd400) begin errors++; $display("FAIL coll_respawn2_x got=%0d exp=400", rival_x); end
    $display("test_collision y=%0d x=%0d", rival_y, rival_x);
  endtask

  task automatic test_saturate;
    SCROLL_SPEED_Y = 4'd15;
    frames(27);
    checks++; if (rival_y !== 10'd459) begin errors++; $display("FAIL sat_459 got=%0d exp=459", rival_y); end
    SCROLL_SPEED_Y = 4'd9;
    frames(1);
    checks++; if (rival_y !== 10'd470) begin errors++; $display("FAIL sat_470 got=%0d exp=470", rival_y); end
    SCROLL_SPEED_Y = 4'd15;
    frames(1);
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL sat_clamp got=%0d exp=480", rival_y); end
    repeat (5) @(negedge clk);
    checks++; if (rival_y !== 10'd480) begin errors++; $display("FAIL sat_hold got=%0d exp=480", rival_y); end
    $display("test_saturate y=%0d", rival_y);
  endtask

  task automatic test_scroll_zero;
    rnd = 8'h01;
    frames(8);
    checks++; if (rival_x !== 10'd272) begin errors++; $display("FAIL zero_respawn_x got=%0d exp=272", rival_x); end
    SCROLL_SPEED_Y = 4'd0;
    frames(10);
    checks++; if (rival_y !== 10'd20) begin errors++; $display("FAIL zero_speed got=%0d exp=20", rival_y); end
    $display("test_scroll_zero y=%0d", rival_y);
  endtask

  task automatic test_mid_reset;
    @(negedge clk); reset = 1'b1; frame_end = 1'b1; collide_with_rival = 1'b1;
    @(negedge clk); reset = 1'b0; frame_end = 1'b0; collide_with_rival = 1'b0;
    checks++; if (rival_x !== 10'd208) begin errors++; $display("FAIL midreset_x got=%0d exp=208", rival_x); end
    checks++; if (rival_y !== 10'd0) begin errors++; $display("FAIL midreset_y got=%0d exp=0", rival_y); end
    frames(1);
    checks++; if (rival_y !== 10'd2) begin errors++; $display("FAIL midreset_active got=%0d exp=2", rival_y); end
    $display("test_mid_reset y=%0d", rival_y);
  endtask

  initial begin
    test_reset();
    test_descent();
    test_respawn();
    test_collision();
    test_saturate();
    test_scroll_zero();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rival_car_core.md
Name: rival_car_core

Overview:
- Controls one rival (obstacle) car in the top-down racing game on the 640x480 VGA pipeline.
- Once per video frame, on the `frame_end` pulse, it advances the car down the screen.
- When the car leaves the bottom of the screen or collides with the player, it is removed.
- After a hold-off of whole frames it respawns at the top, in a lane chosen from an external 8-bit pseudo-random value (`rnd`, produced by the existing `random` LFSR block).
- Outputs drive the sprite renderer and the collision detector.

Parameters:
- SCREEN_H, 480, y value at which the car is off-screen. Also the "hidden" y value.
- ROAD_X_MIN, 192, x of the left road edge.
- LANE_W, 64, lane width in pixels. There are 4 lanes.
- LANE_OFFSET, 16, x offset of the car within its lane.
- BASE_SPEED, 2, rival car's own speed in pixels/frame, added to the scroll speed.
- SPEED_W, 4, width of SCROLL_SPEED_Y.
- RESPAWN_FRAMES, 8, frame_end pulses spent hidden before respawn.

Ports:
- clk  in  1  system clock. Everything is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- frame_end  in  1  one-clk pulse at the end of each video frame.
- rnd  in  8  pseudo-random value, sampled only at respawn.
- collide_with_rival  in  1  level from the collision detector. High while the player overlaps the rival.
- SCROLL_SPEED_Y  in  SPEED_W  road scroll speed in pixels/frame. Narrower drivers are zero-extended.
- rival_x  out  10  left x of the rival sprite.
- rival_y  out  10  top y of the rival sprite.

Behaviour:
- Single clock `clk`; `reset` is synchronous and active-high.
- Reset:
  - state = ACTIVE
  - rival_x = ROAD_X_MIN + LANE_OFFSET (= 208)
  - rival_y = 0
  - frame counter = 0
- Reset takes priority over all other inputs. Asserting it mid-operation returns the block to the reset values on the next edge.
- Lane-to-x mapping: lane = rnd[1:0]. rival_x = ROAD_X_MIN + lane*LANE_W + LANE_OFFSET, giving 208 / 272 / 336 / 400 for lanes 0–3. Computed in 10-bit unsigned arithmetic.
- All outputs are registered. Updates happen on the clk edge where the relevant input is sampled.
- State ACTIVE:
  - If collide_with_rival = 1: go to WAIT, rival_y = SCREEN_H, counter cleared. Collision has priority over motion in the same cycle.
  - Else, on frame_end: next = rival_y + BASE_SPEED + SCROLL_SPEED_Y, computed 11 bits wide.
    - If next >= SCREEN_H: rival_y = SCREEN_H (saturates) and go to WAIT, counter cleared.
    - Otherwise rival_y = next.
  - rival_x is held.
- State WAIT:
  - rival_y is held at SCREEN_H (car hidden). collide_with_rival is ignored.
  - Each frame_end increments the counter.
  - On the frame_end that brings the counter to RESPAWN_FRAMES: rival_y = 0, rival_x = lane x from rnd sampled that cycle, state = ACTIVE.
- frame_end with no state change leaves the outputs unchanged. rival_x and rival_y never glitch between frames.
- SCROLL_SPEED_Y = 0 still moves the car at BASE_SPEED.

Optional Feature:
- Macro RIVAL_LANE_AVOID_EN.
- When defined: a 2-bit register remembers the previous lane. If rnd[1:0] equals it at respawn, the lane used is (rnd[1:0] + 1) mod 4, so consecutive spawns never share a lane. The register resets to 0.
- When undefined: the lane is rnd[1:0] unmodified and the register is not built.

Decomposition:
- Shared package `game_pkg`:
  - SCREEN_H, ROAD_X_MIN, LANE_W, LANE_OFFSET
  - the state typedef {ACTIVE, WAIT}
  - a lane-to-x function
- The `random` 8-bit LFSR stays a separate existing block, instantiated beside this one and not inside it.
- One natural sub-module is `rival_lane_sel`: rnd plus previous lane in, x out, containing the RIVAL_LANE_AVOID_EN logic.

Test Plan:
- Reset pulse of 10 cycles -> rival_x = 208, rival_y = 0, state ACTIVE.
- SCROLL_SPEED_Y = 1, 125 frame_end pulses -> rival_y = 375 (> 372). After frame 160, rival_y = 480 and state WAIT.
- In WAIT, after 8 frame_end pulses with rnd = 8'h02 -> rival_y = 0, rival_x = 336. Repeat for three full passes, checking rival_y climbs again past 372 each time.
- collide_with_rival = 1 while rival_y = 90, on the same cycle as frame_end -> rival_y = 480 (not 93), state WAIT. Collision during WAIT has no effect.
- SCROLL_SPEED_Y = 15, rival_y = 470, frame_end -> rival_y saturates to 480. No wrap to a small value.
- With RIVAL_LANE_AVOID_EN defined and rnd = 8'h00 on two consecutive respawns -> x = 208, then 272.
